// File: rtl/pcs_pkg.sv
// Shared encodings for the program-counter sequencer: op codes, fault codes,
// FSM state type and the instruction-size helper.
package pcs_pkg;

    localparam logic [2:0] OP_NEXT   = 3'd0;
    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_BRANCH = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;

    localparam logic [1:0] FLT_NONE = 2'd0;
    localparam logic [1:0] FLT_OVF  = 2'd1;
    localparam logic [1:0] FLT_UDF  = 2'd2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } pcs_state_e;

    // A zero-length instruction is treated as one byte so the PC always advances.
    function automatic logic [1:0] eff_size(input logic [1:0] sz);
        return (sz == 2'd0) ? 2'd1 : sz;
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. Push and pop are mutually exclusive; push on full
// and pop on empty are ignored here, the sequencer turns them into faults.
module return_stack
    import pcs_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4,
    localparam int SP_W  = $clog2(STACK_DEPTH + 1),
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] din,
    output logic [ADDR_WIDTH-1:0] dout,
    output logic [SP_W-1:0]       sp,
    output logic                  full,
    output logic                  empty
);

    logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]       sp_q;
    logic [SP_W-1:0]       sp_m1;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;

    assign sp     = sp_q;
    assign full   = (sp_q == SP_W'(STACK_DEPTH));
    assign empty  = (sp_q == '0);
    assign sp_m1  = sp_q - SP_W'(1);
    assign wr_idx = sp_q[IDX_W-1:0];
    assign rd_idx = sp_m1[IDX_W-1:0];
    assign dout   = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_m1;
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next/jump/branch/call/return with a RUN/FAULT FSM.
// Define PCS_IRQ_EN to add the irq/irq_ack interrupt entry path.
module pc_sequencer
    import pcs_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
`ifdef PCS_IRQ_EN
    parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR = ADDR_WIDTH'(8'hF0),
`endif
    localparam int SP_W = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic [2:0]            op,
    input  logic [1:0]            instr_size,
    input  logic                  cond,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic [ADDR_WIDTH-1:0] rel_offset,
`ifdef PCS_IRQ_EN
    input  logic                  irq,
    output logic                  irq_ack,
`endif
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [SP_W-1:0]       sp,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  fault,
    output logic [1:0]            fault_code,
    output logic                  dbg_state
);

    pcs_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]            code_q, code_d;
    logic [ADDR_WIDTH-1:0] fallthrough;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] push_data;
    logic [ADDR_WIDTH-1:0] stack_top;
    logic                  op_en;
`ifdef PCS_IRQ_EN
    logic                  in_service_q, in_service_d;
    logic                  irq_ack_q, irq_ack_d;
`endif

    return_stack #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (stack_top),
        .sp    (sp),
        .full  (stack_full),
        .empty (stack_empty)
    );

    assign fallthrough = pc_q + ADDR_WIDTH'(eff_size(instr_size));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        code_d    = code_q;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = fallthrough;
        op_en     = (state_q == ST_RUN) && !halt;
`ifdef PCS_IRQ_EN
        in_service_d = in_service_q;
        irq_ack_d    = 1'b0;
        // A pending interrupt replaces the presented op; pc_q is pushed so the
        // interrupted instruction re-executes after the handler returns.
        if (op_en && irq && !in_service_q) begin
            op_en = 1'b0;
            if (stack_full) begin
                state_d = ST_FAULT;
                code_d  = FLT_OVF;
            end else begin
                push         = 1'b1;
                push_data    = pc_q;
                pc_d         = IRQ_VECTOR;
                in_service_d = 1'b1;
                irq_ack_d    = 1'b1;
            end
        end
`endif
        if (op_en) begin
            case (op)
                OP_JUMP:   pc_d = target;
                OP_BRANCH: pc_d = cond ? (fallthrough + rel_offset) : fallthrough;
                OP_CALL: begin
                    if (stack_full) begin
                        state_d = ST_FAULT;
                        code_d  = FLT_OVF;
                    end else begin
                        push = 1'b1;
                        pc_d = target;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        state_d = ST_FAULT;
                        code_d  = FLT_UDF;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stack_top;
`ifdef PCS_IRQ_EN
                        in_service_d = 1'b0;
`endif
                    end
                end
                default:   pc_d = fallthrough;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            code_q  <= FLT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            code_q  <= code_d;
        end
    end

`ifdef PCS_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_service_q <= 1'b0;
            irq_ack_q    <= 1'b0;
        end else begin
            in_service_q <= in_service_d;
            irq_ack_q    <= irq_ack_d;
        end
    end

    assign irq_ack = irq_ack_q;
`endif

    assign pc         = pc_q;
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = code_q;
    assign dbg_state  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written fault/reset
// sequences, then random ops checked against a queue-based reference model.
module tb_pc_sequencer;

    localparam int W = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       halt = 1'b0;
    logic [2:0] op = 3'd0;
    logic [1:0] instr_size = 2'd1;
    logic       cond = 1'b0;
    logic [W-1:0] target = '0;
    logic [W-1:0] rel_offset = '0;
    logic [W-1:0] pc;
    logic [2:0] sp;
    logic       stack_full, stack_empty, fault, dbg_state;
    logic [1:0] fault_code;
`ifdef PCS_IRQ_EN
    logic       irq = 1'b0;
    logic       irq_ack;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_pc;
    int m_stack[$];
    bit m_fault;
    int m_code;

    pc_sequencer #(
        .ADDR_WIDTH   (W),
        .STACK_DEPTH  (DEPTH),
        .RESET_VECTOR (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .op          (op),
        .instr_size  (instr_size),
        .cond        (cond),
        .target      (target),
        .rel_offset  (rel_offset),
`ifdef PCS_IRQ_EN
        .irq         (irq),
        .irq_ack     (irq_ack),
`endif
        .pc          (pc),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .fault       (fault),
        .fault_code  (fault_code),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [1:0] size;
        logic       cond;
        logic [7:0] target;
        logic [7:0] offset;
        logic       halt;
        int         exp_pc;
        int         exp_sp;
        int         exp_fault;
        int         exp_code;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_fault = 0;
        m_code = 0;
    endtask

    task automatic model_step(input int o, input int sz, input bit c, input int t,
                              input int off, input bit h);
        int ft;
        if (m_fault || h) return;
        ft = (m_pc + ((sz == 0) ? 1 : sz)) % 256;
        case (o)
            1: m_pc = t;
            2: m_pc = c ? (ft + off) % 256 : ft;
            3: begin
                if (m_stack.size() == DEPTH) begin
                    m_fault = 1;
                    m_code = 1;
                end else begin
                    m_stack.push_back(ft);
                    m_pc = t;
                end
            end
            4: begin
                if (m_stack.size() == 0) begin
                    m_fault = 1;
                    m_code = 2;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end
            default: m_pc = ft;
        endcase
    endtask

    // Drive one op just after an edge, let it be sampled, then look #1 after.
    task automatic step(input logic [2:0] o, input logic [1:0] sz, input logic c,
                        input logic [7:0] t, input logic [7:0] off, input logic h);
        op = o;
        instr_size = sz;
        cond = c;
        target = t;
        rel_offset = off;
        halt = h;
        @(posedge clk);
        #1;
        model_step(int'(o), int'(sz), c, int'(t), int'(off), h);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"}, int'(pc), m_pc);
        chk({tag, ".sp"}, int'(sp), m_stack.size());
        chk({tag, ".fault"}, int'(fault), int'(m_fault));
        chk({tag, ".code"}, int'(fault_code), m_code);
        chk({tag, ".full"}, int'(stack_full), int'(m_stack.size() == DEPTH));
        chk({tag, ".empty"}, int'(stack_empty), int'(m_stack.size() == 0));
        chk({tag, ".state"}, int'(dbg_state), int'(m_fault));
    endtask

    initial begin
        //            op size c  target offset h   pc     sp f code
        tbl[0]  = '{3'd0, 2'd1, 0, 8'h00, 8'h00, 0, 'h01, 0, 0, 0};
        tbl[1]  = '{3'd0, 2'd2, 0, 8'h00, 8'h00, 0, 'h03, 0, 0, 0};
        tbl[2]  = '{3'd0, 2'd3, 0, 8'h00, 8'h00, 0, 'h06, 0, 0, 0};
        tbl[3]  = '{3'd0, 2'd0, 0, 8'h00, 8'h00, 0, 'h07, 0, 0, 0};
        tbl[4]  = '{3'd1, 2'd1, 0, 8'hFE, 8'h00, 0, 'hFE, 0, 0, 0};
        tbl[5]  = '{3'd0, 2'd3, 0, 8'h00, 8'h00, 0, 'h01, 0, 0, 0};
        tbl[6]  = '{3'd1, 2'd1, 0, 8'h10, 8'h00, 0, 'h10, 0, 0, 0};
        tbl[7]  = '{3'd2, 2'd2, 1, 8'h00, 8'hF0, 0, 'h02, 0, 0, 0};
        tbl[8]  = '{3'd1, 2'd1, 0, 8'h10, 8'h00, 0, 'h10, 0, 0, 0};
        tbl[9]  = '{3'd2, 2'd2, 0, 8'h00, 8'hF0, 0, 'h12, 0, 0, 0};
        tbl[10] = '{3'd1, 2'd1, 0, 8'h20, 8'h00, 0, 'h20, 0, 0, 0};
        tbl[11] = '{3'd3, 2'd3, 0, 8'h40, 8'h00, 0, 'h40, 1, 0, 0};
        tbl[12] = '{3'd3, 2'd2, 0, 8'h60, 8'h00, 0, 'h60, 2, 0, 0};
        tbl[13] = '{3'd3, 2'd1, 0, 8'h80, 8'h00, 1, 'h60, 2, 0, 0};
        tbl[14] = '{3'd4, 2'd1, 0, 8'h00, 8'h00, 0, 'h42, 1, 0, 0};
        tbl[15] = '{3'd4, 2'd1, 0, 8'h00, 8'h00, 0, 'h23, 0, 0, 0};
        tbl[16] = '{3'd4, 2'd1, 0, 8'h00, 8'h00, 0, 'h23, 0, 1, 2};
        tbl[17] = '{3'd0, 2'd1, 0, 8'h00, 8'h00, 0, 'h23, 0, 1, 2};

        // Clock/reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.pc", int'(pc), 0);
        chk("reset.sp", int'(sp), 0);
        chk("reset.empty", int'(stack_empty), 1);
        chk("reset.fault", int'(fault), 0);
        chk("reset.code", int'(fault_code), 0);
        rst = 1'b0;
        model_reset();

        // Directed table
        foreach (tbl[i]) begin
            step(tbl[i].op, tbl[i].size, tbl[i].cond, tbl[i].target, tbl[i].offset, tbl[i].halt);
            chk($sformatf("tbl%0d.pc", i), int'(pc), tbl[i].exp_pc);
            chk($sformatf("tbl%0d.sp", i), int'(sp), tbl[i].exp_sp);
            chk($sformatf("tbl%0d.fault", i), int'(fault), tbl[i].exp_fault);
            chk($sformatf("tbl%0d.code", i), int'(fault_code), tbl[i].exp_code);
            chk($sformatf("tbl%0d.empty", i), int'(stack_empty), int'(tbl[i].exp_sp == 0));
        end

        // Async reset out of FAULT, visible before any clock edge
        rst = 1'b1;
        #1;
        chk("async_rst.pc", int'(pc), 0);
        chk("async_rst.fault", int'(fault), 0);
        chk("async_rst.code", int'(fault_code), 0);
        #1;
        rst = 1'b0;
        model_reset();

        // Async reset mid-run
        step(3'd1, 2'd1, 0, 8'h55, 8'h00, 0);
        step(3'd3, 2'd1, 0, 8'h77, 8'h00, 0);
        chk("midrun.pc", int'(pc), 'h77);
        rst = 1'b1;
        #1;
        chk("midrun_rst.pc", int'(pc), 0);
        chk("midrun_rst.sp", int'(sp), 0);
        #1;
        rst = 1'b0;
        model_reset();

        // Five CALLs against depth 4: the fifth overflows and freezes everything
        for (int i = 0; i < 4; i++) begin
            step(3'd3, 2'd1, 0, 8'(8'h40 + 16 * i), 8'h00, 0);
            chk($sformatf("call%0d.pc", i), int'(pc), 'h40 + 16 * i);
            chk($sformatf("call%0d.sp", i), int'(sp), i + 1);
        end
        chk("call4.full", int'(stack_full), 1);
        step(3'd3, 2'd1, 0, 8'hA0, 8'h00, 0);
        chk("ovf.fault", int'(fault), 1);
        chk("ovf.code", int'(fault_code), 1);
        chk("ovf.pc", int'(pc), 'h70);
        step(3'd4, 2'd1, 0, 8'h00, 8'h00, 1);
        step(3'd1, 2'd1, 0, 8'h99, 8'h00, 0);
        step(3'd4, 2'd1, 0, 8'h00, 8'h00, 0);
        chk("frozen.pc", int'(pc), 'h70);
        chk("frozen.sp", int'(sp), 4);
        chk("frozen.fault", int'(fault), 1);
        chk("frozen.code", int'(fault_code), 1);
        pulse_reset();
        chk("ovf_rst.pc", int'(pc), 0);
        chk("ovf_rst.sp", int'(sp), 0);

`ifdef PCS_IRQ_EN
        step(3'd1, 2'd1, 0, 8'h30, 8'h00, 0);
        irq = 1'b1;
        step(3'd1, 2'd1, 0, 8'h88, 8'h00, 0);
        chk("irq.pc", int'(pc), 'hF0);
        chk("irq.ack", int'(irq_ack), 1);
        chk("irq.sp", int'(sp), 1);
        step(3'd0, 2'd1, 0, 8'h00, 8'h00, 0);
        chk("irq_nest.pc", int'(pc), 'hF1);
        chk("irq_nest.ack", int'(irq_ack), 0);
        chk("irq_nest.sp", int'(sp), 1);
        irq = 1'b0;
        step(3'd4, 2'd1, 0, 8'h00, 8'h00, 0);
        chk("irq_ret.pc", int'(pc), 'h30);
        chk("irq_ret.sp", int'(sp), 0);
        irq = 1'b1;
        step(3'd0, 2'd1, 0, 8'h00, 8'h00, 0);
        chk("irq2.pc", int'(pc), 'hF0);
        chk("irq2.ack", int'(irq_ack), 1);
        irq = 1'b0;
        pulse_reset();
`endif

        // Randomized ops against the reference model
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [2:0] o;
            r = $urandom_range(0, 9);
            case (r)
                0, 1: o = 3'd0;
                2:    o = 3'd1;
                3, 4: o = 3'd2;
                5, 6: o = 3'd3;
                7, 8: o = 3'd4;
                default: o = 3'($urandom_range(5, 7));
            endcase
            step(o, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) == 0));
            chk_model($sformatf("rnd%0d", n));
            if (m_fault && $urandom_range(0, 3) == 0) begin
                pulse_reset();
                chk_model($sformatf("rnd%0d_rst", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer. Successor to the plain PC; adds relative branches, call/return through an internal return-address stack, and fault detection.
- Sits between the decoder (op, size, target, offset, cond) and instruction fetch (pc).
- A two-state FSM (RUN, FAULT) freezes the PC on stack misuse until reset.

Parameters:
ADDR_WIDTH, 8, PC / address width in bits.
STACK_DEPTH, 4, return-stack entries (>=1).
RESET_VECTOR, 0, PC value loaded on reset.
IRQ_VECTOR, 8'hF0, interrupt entry address (used only with PCS_IRQ_EN).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
halt  in  1  freezes all state when high.
op  in  3  0=NEXT, 1=JUMP, 2=BRANCH, 3=CALL, 4=RET, 5-7 treated as NEXT.
instr_size  in  2  bytes in current instruction; 0 treated as 1.
cond  in  1  branch condition, sampled for BRANCH only.
target  in  ADDR_WIDTH  absolute target for JUMP/CALL.
rel_offset  in  ADDR_WIDTH  two's-complement offset for BRANCH.
pc  out  ADDR_WIDTH  current PC.
sp  out  $clog2(STACK_DEPTH+1)  stack occupancy.
stack_full  out  1  sp==STACK_DEPTH.
stack_empty  out  1  sp==0.
fault  out  1  sticky fault flag (high in FAULT state).
fault_code  out  2  0=none, 1=overflow, 2=underflow.

Behaviour:
- Reset (async, any time, including mid-fault): pc=RESET_VECTOR, sp=0, stack contents don't-care, state=RUN, fault=0, fault_code=0.
- All updates on posedge clk. Every op has 1-cycle latency: new pc is visible the cycle after op is presented.
- fallthrough = pc + size, where size = instr_size, or 1 when instr_size is 0. Arithmetic is modulo 2^ADDR_WIDTH and wraps (e.g. FF+2 -> 01 at W=8).
- Priority: rst > FAULT state > halt > op.
- halt=1: pc, sp, stack and state all hold; op is ignored.
- NEXT: pc <= fallthrough.
- JUMP: pc <= target.
- BRANCH: if cond, pc <= fallthrough + rel_offset (mod 2^W); otherwise pc <= fallthrough.
- CALL:
  - Not full: stack[sp] <= fallthrough, sp++, pc <= target.
  - Full: no push, pc holds, state -> FAULT, fault_code=1.
- RET:
  - Not empty: pc <= stack[sp-1], sp--.
  - Empty: pc holds, state -> FAULT, fault_code=2.
- FAULT: pc, sp and stack frozen; fault=1; exit only via rst.
- stack_full / stack_empty are combinational from sp.

Optional Feature:
PCS_IRQ_EN
- Enabled: adds ports irq (in, 1) and irq_ack (out, 1, reset 0), plus an internal in_service bit (reset 0).
- Taking an interrupt:
  - Condition: irq=1 and in_service=0 in RUN with halt=0.
  - The interrupt overrides op: push pc (the current instruction is not executed), pc <= IRQ_VECTOR, in_service <= 1, irq_ack=1 for exactly that one cycle.
  - If the stack is full, enter FAULT with code 1 instead.
- The next successful RET clears in_service.
- irq is ignored while in_service=1; no nesting.
- Disabled: no irq/irq_ack ports, no in_service logic; behaviour exactly as above.

Decomposition:
- Package pcs_pkg holds:
  - Op encodings: OP_NEXT, OP_JUMP, OP_BRANCH, OP_CALL, OP_RET.
  - Fault codes: FLT_NONE, FLT_OVF, FLT_UDF.
  - FSM state enum: ST_RUN, ST_FAULT.
- Sub-module return_stack(ADDR_WIDTH, STACK_DEPTH): LIFO with push/pop/din/dout/sp/full/empty.
  - Push and pop are mutually exclusive.
  - Async reset of sp only.
- The sequencer owns FSM, next-pc mux and fault logic.

Test Plan:
- Reset, NEXT with sizes 1,2,3,0 -> pc 00,01,03,06,07; rst pulsed mid-run -> pc=00 immediately (async).
- pc=FE, NEXT size=3 -> pc=01 (wrap); BRANCH at pc=10, size=2, offset=F0, cond=1 -> pc=02; same with cond=0 -> pc=12.
- Nested CALLs at W=8, depth 4:
  - CALL at 20 (size 3, target 40), then CALL at 40 (size 2, target 60).
  - RET -> pc=42, RET -> pc=23, sp returns 2->1->0, stack_empty=1.
- Five CALLs with depth 4 -> 5th sets fault=1, fault_code=1, pc frozen; later ops and halt toggling have no effect until rst.
- RET on empty stack -> fault_code=2, pc unchanged; halt=1 held during a CALL -> pc and sp unchanged.
- (PCS_IRQ_EN) irq=1 at pc=30 -> pc=F0, irq_ack for 1 cycle, sp=1; a second irq while in service is ignored; RET -> pc=30, after which a new irq is accepted.
